tx_link_ctrl: RTL and testbench

TX_LINK_CTRL -- requirements
Module: tx_link_ctrl

---
 rtl/tx_link_ctrl.sv | 176 +++++++++++++++++
 tb/tb_tx_link_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_link_ctrl.sv
// tx_link_ctrl: transmit link controller. It sequences comma training, payload
// transfer and periodic SKP ordered sets, one symbol per SYM_CYCLES clocks.
module tx_link_ctrl #(
  parameter int unsigned SYM_CYCLES   = 10,
  parameter int unsigned N_COMMA      = 4,
  parameter int unsigned SKP_INTERVAL = 64
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] data_out,
  output logic       K_out,
  output logic       ENB,
  output logic       sym_load,
  output logic [1:0] state
);

  localparam int unsigned CW = $clog2(SYM_CYCLES);
  localparam int unsigned TW = (N_COMMA > 1) ? $clog2(N_COMMA) : 1;
  localparam int unsigned SW = $clog2(SKP_INTERVAL + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(SYM_CYCLES - 1);
  localparam logic [TW-1:0] TRAIN_LAST = TW'(N_COMMA - 1);
  localparam logic [SW-1:0] SKP_LAST   = SW'(SKIP_DONE_SYMS());

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;

  function automatic int unsigned SKIP_DONE_SYMS();
    return SKP_INTERVAL;
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAIN  = 2'd1,
    ACTIVE = 2'd2,
    SKIP   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] train_cnt_q, train_cnt_d;
  logic [SW-1:0] skp_cnt_q, skp_cnt_d;
  logic          skp_pending_q, skp_pending_d;
  logic [1:0]    set_idx_q, set_idx_d;
  logic [7:0]    data_q, data_d;
  logic          k_q, k_d;
  logic          boundary;

  assign boundary = (cnt_q == CNT_LAST);
  assign in_ready = (state_q == ACTIVE) && boundary && en && !skp_pending_q;
  assign sym_load = (state_q != IDLE) && (cnt_q == '0);
  assign ENB      = (state_q != IDLE);
  assign data_out = data_q;
  assign K_out    = k_q;
  assign state    = state_q;

  // Next-state, symbol counter and next-symbol selection.
  always_comb begin
    state_d       = state_q;
    train_cnt_d   = train_cnt_q;
    skp_cnt_d     = skp_cnt_q;
    skp_pending_d = skp_pending_q;
    set_idx_d     = set_idx_q;
    data_d        = data_q;
    k_d           = k_q;
    if (state_q == IDLE || boundary) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (en) begin
          state_d       = TRAIN;
          train_cnt_d   = '0;
          skp_cnt_d     = '0;
          skp_pending_d = 1'b0;
          data_d        = COM;
          k_d           = 1'b1;
        end
      end
      TRAIN: begin
        if (boundary) begin
          if (!en) begin
            state_d     = IDLE;
            train_cnt_d = '0;
            data_d      = '0;
            k_d         = 1'b0;
          end else if (train_cnt_q == TRAIN_LAST) begin
            state_d       = ACTIVE;
            train_cnt_d   = '0;
            skp_cnt_d     = '0;
            skp_pending_d = 1'b0;
            data_d        = '0;
            k_d           = 1'b0;
          end else begin
            train_cnt_d = train_cnt_q + TW'(1);
            data_d      = COM;
            k_d         = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (boundary) begin
          if (!en) begin
            state_d       = IDLE;
            skp_cnt_d     = '0;
            skp_pending_d = 1'b0;
            data_d        = '0;
            k_d           = 1'b0;
          end else if (skp_pending_q) begin
            state_d   = SKIP;
            set_idx_d = '0;
            data_d    = COM;
            k_d       = 1'b1;
          end else begin
            // Payload byte on a handshake, otherwise an idle filler symbol.
            data_d    = in_valid ? in_data : 8'h00;
            k_d       = 1'b0;
            skp_cnt_d = skp_cnt_q + SW'(1);
            if (skp_cnt_q + SW'(1) == SKP_LAST) begin
              skp_pending_d = 1'b1;
            end
          end
        end
      end
      SKIP: begin
        if (boundary) begin
          if (set_idx_q == 2'd3) begin
            // Ordered set always completes; en is only honoured at its end.
            state_d       = en ? ACTIVE : IDLE;
            set_idx_d     = '0;
            skp_cnt_d     = '0;
            skp_pending_d = 1'b0;
            data_d        = '0;
            k_d           = 1'b0;
          end else begin
            set_idx_d = set_idx_q + 2'd1;
            data_d    = SKP;
            k_d       = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      train_cnt_q   <= '0;
      skp_cnt_q     <= '0;
      skp_pending_q <= 1'b0;
      set_idx_q     <= '0;
      data_q        <= '0;
      k_q           <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      train_cnt_q   <= train_cnt_d;
      skp_cnt_q     <= skp_cnt_d;
      skp_pending_q <= skp_pending_d;
      set_idx_q     <= set_idx_d;
      data_q        <= data_d;
      k_q           <= k_d;
    end
  end

endmodule

// File: tb/tb_tx_link_ctrl.sv
// Testbench for tx_link_ctrl: randomized payload against a symbol-level model.
module tb_tx_link_ctrl;

  localparam int unsigned SYM   = 10;
  localparam int unsigned NC    = 4;
  localparam int unsigned SKPI  = 8;
  // Symbols per ACTIVE epoch: entry idle, SKPI payload slots, 4-symbol ordered set.
  localparam int unsigned EPOCH = SKPI + 5;

  logic       CLK = 1'b0;
  logic       reset;
  logic       en;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_out;
  logic       K_out;
  logic       ENB;
  logic       sym_load;
  logic [1:0] state;

  tx_link_ctrl #(
    .SYM_CYCLES  (SYM),
    .N_COMMA     (NC),
    .SKP_INTERVAL(SKPI)
  ) dut (
    .CLK     (CLK),
    .reset   (reset),
    .en      (en),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_out(data_out),
    .K_out   (K_out),
    .ENB     (ENB),
    .sym_load(sym_load),
    .state   (state)
  );

  always #5 CLK = ~CLK;

  int          total = 0;
  int          bad   = 0;
  int unsigned act_k;
  logic [7:0]  slot_data;
  logic [7:0]  next_byte;
  int unsigned xfers;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] obs;
    reset = 1'b0; en = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      obs = {state, ENB, sym_load, K_out, data_out};
      total++;
      if (obs !== 13'd0 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL reset_state: got %h ready=%b want 0000 ready=0", obs, in_ready);
      end
    end
    en = 1'b0; in_valid = 1'b0;
  endtask

  // Expects en=1 with the DUT in IDLE; checks the full comma training sequence.
  task automatic run_train();
    logic [10:0] obs, exp;
    for (int unsigned i = 0; i < NC * SYM; i++) begin
      step();
      obs = {state, ENB, sym_load, in_ready, K_out, data_out[4:0]};
      exp = {2'd1, 1'b1, (i % SYM == 0), 1'b0, 1'b1, 5'h1C};
      total++;
      if (obs !== exp || data_out !== 8'hBC) begin
        bad++;
        $display("FAIL train_cycle%0d: got %h data=%h want %h data=bc", i, obs, data_out, exp);
      end
    end
    step();
    total++;
    if ({state, sym_load, K_out, data_out} !== {2'd2, 1'b1, 1'b0, 8'h00}) begin
      bad++;
      $display("FAIL train_to_active: got st=%0d ld=%b k=%b d=%h want st=2 ld=1 k=0 d=00",
               state, sym_load, K_out, data_out);
    end
    act_k = 0;
  endtask

  task automatic test_train();
    reset = 1'b1;
    en    = 1'b1;
    run_train();
  endtask

  // One ACTIVE/SKIP symbol from its first cycle to the next symbol's first cycle.
  task automatic run_symbol(input int unsigned pct);
    int unsigned pos;
    logic [7:0]  ed;
    logic        ek, er;
    logic [1:0]  es;
    pos = act_k % EPOCH;
    ek  = (pos > SKPI);
    es  = (pos <= SKPI) ? 2'd2 : 2'd3;
    if (pos == 0)             ed = 8'h00;
    else if (pos <= SKPI)     ed = slot_data;
    else if (pos == SKPI + 1) ed = 8'hBC;
    else                      ed = 8'h1C;
    total++;
    if ({state, ENB, sym_load, K_out, data_out} !== {es, 1'b1, 1'b1, ek, ed}) begin
      bad++;
      $display("FAIL sym%0d_start: got st=%0d enb=%b ld=%b k=%b d=%h want st=%0d enb=1 ld=1 k=%b d=%h",
               act_k, state, ENB, sym_load, K_out, data_out, es, ek, ed);
    end
    for (int unsigned c = 1; c < SYM; c++) begin
      step();
      if (c < SYM - 1) begin
        total++;
        if ({sym_load, in_ready, K_out, data_out} !== {1'b0, 1'b0, ek, ed}) begin
          bad++;
          $display("FAIL sym%0d_hold_c%0d: got ld=%b rdy=%b k=%b d=%h want ld=0 rdy=0 k=%b d=%h",
                   act_k, c, sym_load, in_ready, K_out, data_out, ek, ed);
        end
      end else begin
        in_valid = ($urandom_range(99) < pct);
        in_data  = in_valid ? next_byte : 8'($urandom);
        er = (pos < SKPI);
        total++;
        if (in_ready !== er) begin
          bad++;
          $display("FAIL sym%0d_ready: got %b want %b", act_k, in_ready, er);
        end
        if (er) begin
          slot_data = in_valid ? next_byte : 8'h00;
          if (in_valid) begin
            next_byte = next_byte + 8'd1;
            xfers++;
          end
        end
      end
    end
    step();
    act_k++;
  endtask

  task automatic test_stream();
    int unsigned xfers0;
    xfers0 = xfers;
    for (int i = 0; i < 2 * EPOCH; i++) run_symbol(100);
    total++;
    if (xfers - xfers0 !== 2 * SKPI) begin
      bad++;
      $display("FAIL full_rate_xfers: got %0d want %0d", xfers - xfers0, 2 * SKPI);
    end
    for (int i = 0; i < EPOCH; i++) run_symbol(0);
    for (int i = 0; i < 2 * EPOCH; i++) run_symbol(60);
  endtask

  task automatic test_en_drop_active();
    while ((act_k % EPOCH) < 1 || (act_k % EPOCH) >= SKPI) run_symbol(50);
    total++;
    if ({state, sym_load} !== {2'd2, 1'b1}) begin
      bad++;
      $display("FAIL drop_active_start: got st=%0d ld=%b want st=2 ld=1", state, sym_load);
    end
    in_valid = 1'b1;
    in_data  = next_byte;
    for (int i = 0; i < 3; i++) step();
    en = 1'b0;
    for (int i = 3; i < SYM - 1; i++) begin
      step();
      total++;
      if (state !== 2'd2 || ENB !== 1'b1) begin
        bad++;
        $display("FAIL drop_active_finish_c%0d: got st=%0d enb=%b want st=2 enb=1", i + 1, state, ENB);
      end
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL drop_active_ready: got %b want 0", in_ready);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({state, ENB, sym_load, in_ready, K_out, data_out} !== 14'd0) begin
        bad++;
        $display("FAIL drop_active_idle%0d: got st=%0d enb=%b ld=%b rdy=%b k=%b d=%h want all 0",
                 i, state, ENB, sym_load, in_ready, K_out, data_out);
      end
      step();
    end
    in_valid = 1'b0;
    en = 1'b1;
    run_train();
  endtask

  task automatic test_en_drop_skip();
    logic [7:0] ed;
    while ((act_k % EPOCH) != SKPI + 1) run_symbol(70);
    for (int unsigned j = 0; j < 4; j++) begin
      ed = (j == 0) ? 8'hBC : 8'h1C;
      total++;
      if ({state, sym_load, K_out, data_out} !== {2'd3, 1'b1, 1'b1, ed}) begin
        bad++;
        $display("FAIL drop_skip_sym%0d: got st=%0d ld=%b k=%b d=%h want st=3 ld=1 k=1 d=%h",
                 j, state, sym_load, K_out, data_out, ed);
      end
      for (int unsigned c = 1; c <= SYM; c++) begin
        step();
        if (j == 0 && c == 2) en = 1'b0;
      end
    end
    total++;
    if ({state, ENB, sym_load, in_ready, K_out, data_out} !== 14'd0) begin
      bad++;
      $display("FAIL drop_skip_idle: got st=%0d enb=%b ld=%b rdy=%b k=%b d=%h want all 0",
               state, ENB, sym_load, in_ready, K_out, data_out);
    end
    step();
    en = 1'b1;
    run_train();
  endtask

  task automatic test_reset_mid_skip();
    while ((act_k % EPOCH) != SKPI + 1) run_symbol(80);
    for (int i = 0; i < 5; i++) step();
    total++;
    if (state !== 2'd3) begin
      bad++;
      $display("FAIL pre_reset_skip: got st=%0d want 3", state);
    end
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({state, ENB, sym_load, in_ready, K_out, data_out} !== 14'd0) begin
      bad++;
      $display("FAIL async_reset: got st=%0d enb=%b ld=%b rdy=%b k=%b d=%h want all 0",
               state, ENB, sym_load, in_ready, K_out, data_out);
    end
    step();
    step();
    reset = 1'b1;
    run_train();
    for (int i = 0; i < EPOCH + 2; i++) run_symbol(90);
  endtask

  initial begin
    reset     = 1'b0;
    en        = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    slot_data = 8'h00;
    next_byte = 8'h01;
    act_k     = 0;
    xfers     = 0;
    test_reset();
    test_train();
    test_stream();
    test_en_drop_active();
    test_en_drop_skip();
    test_reset_mid_skip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
